flit_sink: RTL and testbench
============================

Name: flit_sink

Overview:
- Receive-side endpoint of the switch port protocol. It is the consumer for one switch output port (typically the local port).
- Accepts flits under the in_w/out_r handshake and reassembles them into packets.
- Checks each packet for destination address, length and payload sequence, and reports per-packet results and counters.
- Used as the IP-side sink in switch and mesh benches, and as the receive half of a traffic IP.

Parameters:
- DATA_SIZE, 8, payload field width of a flit.
- ADDR_SIZE, 2, address field width of a flit.
- ADDR, 0, own node address; all received flits must carry this destination.
- STALL_PERIOD, 0, backpressure period; 0 = never stall, N>=2 = out_r low 1 cycle in every N.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  input  1  clock.
- a_rst  input  1  reset, synchronous, active-high.
- data_i  input  ADDR_SIZE+DATA_SIZE+1  flit {last, dst_addr, data}, MSB first.
- in_w  input  1  sender has a valid flit on data_i.
- out_r  output  1  sink ready to accept.
- pack_done  output  1  one-cycle pulse, a packet closed.
- pack_ok  output  1  closed packet had no error; valid while pack_done=1.
- pack_src  output  ADDR_SIZE  source field of the closed packet's header.
- pack_len  output  DATA_SIZE-ADDR_SIZE  length field of the closed packet's header.
- pack_cnt  output  CNT_W  packets closed (saturating).
- err_cnt  output  CNT_W  packets closed with an error (saturating).
- busy  output  1  high while in BODY or RESYNC.

Behaviour:
- Reset, synchronous on a_rst=1 at posedge clk, also when applied mid-packet:
  - all outputs 0, state HEAD, stall counter 0;
  - out_r stays 0 during reset and is first 1 in the cycle after a_rst falls;
  - any partial packet is discarded and not counted.
- Transfer rules:
  - a flit is accepted at a posedge where in_w=1 and out_r=1;
  - with in_w=1 and out_r=0 nothing is consumed, and the sender holds the flit.
  - out_r is registered. It is low exactly when stall_cnt==STALL_PERIOD-1; stall_cnt wraps 0..STALL_PERIOD-1 every cycle.
- Flit format:
  - last = MSB;
  - header data = {len[DATA_SIZE-ADDR_SIZE-1:0], src[ADDR_SIZE-1:0]};
  - body flit k (k=0..len-1) carries data = k mod 2^DATA_SIZE;
  - len=0 means header-only, and the header has last=1.
- FSM transitions, on accepted flits only:
  - HEAD:
    - latch src and len, clear flags, exp_idx=0;
    - if last=1: close the packet; err_len is set if len!=0;
    - else if len==0: err_len, go to RESYNC;
    - else go to BODY.
  - BODY:
    - data!=exp_idx sets err_seq; exp_idx increments;
    - if last=1: close; err_len is set if exp_idx+1!=len;
    - else if exp_idx+1==len: err_len, go to RESYNC.
  - RESYNC: discard flits until one with last=1, then close (pack_ok=0).
  - Closing a packet always returns the FSM to HEAD.
- dst_addr!=ADDR on any accepted flit sets err_addr; the flit is still consumed and processed normally.
- Close timing:
  - pack_done=1 exactly in the cycle after the accepting edge of the closing flit;
  - pack_src, pack_len and pack_ok are updated on that same edge and hold until the next close;
  - pack_cnt increments on that edge;
  - err_cnt increments on that edge if any of err_addr, err_len or err_seq is set.
- Back-to-back packets: a header accepted in the cycle right after a close is legal, and no idle cycle is required.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Throughput: 1 flit/cycle when STALL_PERIOD=0.

Decomposition:
- Shared package holds:
  - flit field positions: LAST_BIT, ADDR_LO/HI, DATA_LO/HI;
  - header subfield positions: SRC_LO/HI, LEN_LO/HI;
  - FSM state encoding: HEAD, BODY, RESYNC.
- One sub-module: flit_sink_stall, the stall counter and out_r register, reusable by other endpoints.

Test Plan:
Common settings for all scenarios: ADDR=1, DATA_SIZE=8, ADDR_SIZE=2, STALL_PERIOD=0 unless stated.
1. Good packet:
   - stimulus: flits 11'h10E (src=2, len=3), 11'h100, 11'h101, 11'h502, in_w held high;
   - response: pack_done one cycle after 11'h502 accepted; pack_ok=1, pack_src=2, pack_len=3, pack_cnt=1, err_cnt=0.
2. Header-only packet:
   - stimulus: 11'h503 (src=3, len=0, last=1);
   - response: pack_done, pack_ok=1, pack_len=0; a header 11'h106 next cycle is accepted without a gap.
3. Errors:
   - early last: 11'h10E, 11'h100, 11'h501 -> pack_ok=0, err_cnt=1;
   - late last: 11'h106 (len=1), 11'h100, 11'h101, 11'h502 -> RESYNC after 2nd flit, one close, err_cnt=2.
4. Bad sequence and address:
   - bad sequence: body 11'h105 where 11'h100 expected -> pack_ok=0;
   - wrong address: header 11'h00E (dst=0) -> pack_ok=0; the flit is still consumed.
5. Backpressure with STALL_PERIOD=3:
   - response: out_r pattern 1,1,0 repeating after reset;
   - a flit held with in_w=1 during out_r=0 is accepted on the next ready edge, with no duplicate or loss; the 4-flit packet closes correctly.
6. Reset mid-packet:
   - stimulus: a_rst=1 after header 11'h10E and one body flit;
   - response: out_r=0 and pack_cnt=0 during reset; the next full packet is accepted and pack_cnt=1.

Source files
------------

// File: rtl/flit_sink_pkg.sv
// Shared definitions for the flit sink: flit/header field positions and FSM state encoding.
// Positions are functions of the data/address widths so every endpoint can size them itself.
package flit_sink_pkg;

   typedef enum logic [1:0] {
      HEAD   = 2'd0,
      BODY   = 2'd1,
      RESYNC = 2'd2
   } state_e;

   // Flit layout, MSB first: {last, dst_addr, data}
   localparam int DATA_LO = 0;

   function automatic int data_hi(input int data_size);
      return data_size - 1;
   endfunction

   function automatic int addr_lo(input int data_size);
      return data_size;
   endfunction

   function automatic int addr_hi(input int data_size, input int addr_size);
      return data_size + addr_size - 1;
   endfunction

   function automatic int last_bit(input int data_size, input int addr_size);
      return data_size + addr_size;
   endfunction

   // Header data layout: {len, src}
   localparam int SRC_LO = 0;

   function automatic int src_hi(input int addr_size);
      return addr_size - 1;
   endfunction

   function automatic int len_lo(input int addr_size);
      return addr_size;
   endfunction

   function automatic int len_hi(input int data_size);
      return data_size - 1;
   endfunction

endpackage

// File: rtl/flit_sink_stall.sv
// Registered ready generator: out_r_o drops for one cycle in every STALL_PERIOD cycles.
// STALL_PERIOD below 2 means the endpoint never applies backpressure.
module flit_sink_stall #(
   parameter int STALL_PERIOD = 0
) (
   input  logic clk,
   input  logic a_rst,
   output logic out_r_o
);

   logic out_r_q;

   if (STALL_PERIOD < 2) begin : g_nostall
      // NOTE: sequential state uses non-blocking assignments only, reset checked first inside the clocked block.
      always_ff @(posedge clk) begin
         if (a_rst) out_r_q <= 1'b0;
         else       out_r_q <= 1'b1;
      end
   end else begin : g_stall
      localparam int CW = $clog2(STALL_PERIOD);
      localparam logic [CW-1:0] CNT_LAST = CW'(STALL_PERIOD - 1);

      logic [CW-1:0] stall_cnt_q, stall_cnt_d;

      assign stall_cnt_d = (stall_cnt_q == CNT_LAST) ? '0 : stall_cnt_q + CW'(1);

      // Ready is the registered image of the counter so it never depends on the sender.
      always_ff @(posedge clk) begin
         if (a_rst) begin
            stall_cnt_q <= '0;
            out_r_q     <= 1'b0;
         end else begin
            stall_cnt_q <= stall_cnt_d;
            out_r_q     <= (stall_cnt_q != CNT_LAST);
         end
      end
   end

   assign out_r_o = out_r_q;

endmodule

// File: rtl/flit_sink.sv
// Receive-side endpoint: accepts flits, reassembles packets, checks destination, length and
// payload sequence, and reports per-packet results with saturating packet/error counters.
module flit_sink
   import flit_sink_pkg::*;
#(
   parameter int DATA_SIZE    = 8,
   parameter int ADDR_SIZE    = 2,
   parameter int ADDR         = 0,
   parameter int STALL_PERIOD = 0,
   parameter int CNT_W        = 16
) (
   input  logic                          clk,
   input  logic                          a_rst,
   input  logic [ADDR_SIZE+DATA_SIZE:0]  data_i,
   input  logic                          in_w,
   output logic                          out_r,
   output logic                          pack_done,
   output logic                          pack_ok,
   output logic [ADDR_SIZE-1:0]          pack_src,
   output logic [DATA_SIZE-ADDR_SIZE-1:0] pack_len,
   output logic [CNT_W-1:0]              pack_cnt,
   output logic [CNT_W-1:0]              err_cnt,
   output logic                          busy
);

   localparam int LEN_W  = DATA_SIZE - ADDR_SIZE;
   localparam int LAST_B = last_bit(DATA_SIZE, ADDR_SIZE);
   localparam int A_HI   = addr_hi(DATA_SIZE, ADDR_SIZE);
   localparam int A_LO   = addr_lo(DATA_SIZE);
   localparam int D_HI   = data_hi(DATA_SIZE);
   localparam int S_HI   = src_hi(ADDR_SIZE);
   localparam int L_HI   = len_hi(DATA_SIZE);
   localparam int L_LO   = len_lo(ADDR_SIZE);
   localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
   localparam logic [ADDR_SIZE-1:0] OWN_ADDR = ADDR_SIZE'(ADDR);

   logic                 out_r_w, accept;
   logic                 flit_last, addr_bad;
   logic [DATA_SIZE-1:0] flit_data, idx_next, len_ext;
   logic [ADDR_SIZE-1:0] hdr_src;
   logic [LEN_W-1:0]     hdr_len;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] src_q, src_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [DATA_SIZE-1:0] exp_idx_q, exp_idx_d;
   logic                 err_addr_q, err_addr_d;
   logic                 err_len_q, err_len_d;
   logic                 err_seq_q, err_seq_d;
   logic                 close_d, pkt_err_d;

   logic                 pack_done_q, pack_ok_q;
   logic [ADDR_SIZE-1:0] pack_src_q;
   logic [LEN_W-1:0]     pack_len_q;
   logic [CNT_W-1:0]     pack_cnt_q, err_cnt_q;

   flit_sink_stall #(
      .STALL_PERIOD (STALL_PERIOD)
   ) u_stall (
      .clk     (clk),
      .a_rst   (a_rst),
      .out_r_o (out_r_w)
   );

   assign accept    = in_w & out_r_w;
   assign flit_last = data_i[LAST_B];
   assign addr_bad  = (data_i[A_HI:A_LO] != OWN_ADDR);
   assign flit_data = data_i[D_HI:DATA_LO];
   assign hdr_src   = data_i[S_HI:SRC_LO];
   assign hdr_len   = data_i[L_HI:L_LO];
   assign idx_next  = exp_idx_q + DATA_SIZE'(1);
   assign len_ext   = DATA_SIZE'(len_q);
   assign pkt_err_d = err_addr_d | err_len_d | err_seq_d;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      len_d      = len_q;
      exp_idx_d  = exp_idx_q;
      err_addr_d = err_addr_q;
      err_len_d  = err_len_q;
      err_seq_d  = err_seq_q;
      close_d    = 1'b0;
      if (accept) begin
         case (state_q)
            HEAD: begin
               src_d      = hdr_src;
               len_d      = hdr_len;
               exp_idx_d  = '0;
               err_addr_d = addr_bad;
               err_seq_d  = 1'b0;
               err_len_d  = 1'b0;
               if (flit_last) begin
                  close_d   = 1'b1;
                  err_len_d = (hdr_len != '0);
               end else if (hdr_len == '0) begin
                  err_len_d = 1'b1;
                  state_d   = RESYNC;
               end else begin
                  state_d = BODY;
               end
            end
            BODY: begin
               err_addr_d = err_addr_q | addr_bad;
               err_seq_d  = err_seq_q | (flit_data != exp_idx_q);
               exp_idx_d  = idx_next;
               if (flit_last) begin
                  close_d   = 1'b1;
                  err_len_d = err_len_q | (idx_next != len_ext);
                  state_d   = HEAD;
               end else if (idx_next == len_ext) begin
                  // Length reached without last: drop the rest of this packet.
                  err_len_d = 1'b1;
                  state_d   = RESYNC;
               end
            end
            RESYNC: begin
               err_addr_d = err_addr_q | addr_bad;
               if (flit_last) begin
                  close_d = 1'b1;
                  state_d = HEAD;
               end
            end
            default: state_d = HEAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (a_rst) begin
         state_q     <= HEAD;
         src_q       <= '0;
         len_q       <= '0;
         exp_idx_q   <= '0;
         err_addr_q  <= 1'b0;
         err_len_q   <= 1'b0;
         err_seq_q   <= 1'b0;
         pack_done_q <= 1'b0;
         pack_ok_q   <= 1'b0;
         pack_src_q  <= '0;
         pack_len_q  <= '0;
         pack_cnt_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         len_q       <= len_d;
         exp_idx_q   <= exp_idx_d;
         err_addr_q  <= err_addr_d;
         err_len_q   <= err_len_d;
         err_seq_q   <= err_seq_d;
         pack_done_q <= close_d;
         if (close_d) begin
            pack_ok_q  <= ~pkt_err_d;
            pack_src_q <= src_d;
            pack_len_q <= len_d;
            if (pack_cnt_q != CNT_MAX) pack_cnt_q <= pack_cnt_q + CNT_W'(1);
            if (pkt_err_d && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_r     = out_r_w;
   assign pack_done = pack_done_q;
   assign pack_ok   = pack_ok_q;
   assign pack_src  = pack_src_q;
   assign pack_len  = pack_len_q;
   assign pack_cnt  = pack_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign busy      = (state_q != HEAD);

endmodule

// File: tb/tb_flit_sink.sv
// Scoreboard bench for flit_sink: one unstalled sink (16-bit counters) and one sink with
// STALL_PERIOD=3 and 2-bit counters so saturation is reachable in a short run.
module tb_flit_sink;

   typedef struct packed {
      logic       ok;
      logic [1:0] src;
      logic [5:0] len;
   } exp_t;

   logic        clk = 1'b0;
   logic        a_rst;
   logic [10:0] data_a, data_b;
   logic        in_w_a, in_w_b;

   logic        out_r_a, done_a, ok_a, busy_a;
   logic [1:0]  src_a;
   logic [5:0]  len_a;
   logic [15:0] cnt_a, ecnt_a;

   logic        out_r_b, done_b, ok_b, busy_b;
   logic [1:0]  src_b;
   logic [5:0]  len_b;
   logic [1:0]  cnt_b, ecnt_b;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q0[$];
   exp_t sb_q1[$];
   int   exp_pk[2]  = '{0, 0};
   int   exp_er[2]  = '{0, 0};
   int   cnt_max[2] = '{65535, 3};

   always #5 clk = ~clk;

   flit_sink #(
      .DATA_SIZE(8), .ADDR_SIZE(2), .ADDR(1), .STALL_PERIOD(0), .CNT_W(16)
   ) u_dut_a (
      .clk(clk), .a_rst(a_rst), .data_i(data_a), .in_w(in_w_a), .out_r(out_r_a),
      .pack_done(done_a), .pack_ok(ok_a), .pack_src(src_a), .pack_len(len_a),
      .pack_cnt(cnt_a), .err_cnt(ecnt_a), .busy(busy_a)
   );

   flit_sink #(
      .DATA_SIZE(8), .ADDR_SIZE(2), .ADDR(1), .STALL_PERIOD(3), .CNT_W(2)
   ) u_dut_b (
      .clk(clk), .a_rst(a_rst), .data_i(data_b), .in_w(in_w_b), .out_r(out_r_b),
      .pack_done(done_b), .pack_ok(ok_b), .pack_src(src_b), .pack_len(len_b),
      .pack_cnt(cnt_b), .err_cnt(ecnt_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input int sel, input logic ok, input logic [1:0] src, input logic [5:0] len);
      exp_t e;
      e = '{ok: ok, src: src, len: len};
      if (sel == 0) sb_q0.push_back(e);
      else          sb_q1.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_flit(input int sel, input logic [10:0] f, output int waits);
      logic rdy;
      waits = 0;
      if (sel == 0) begin data_a = f; in_w_a = 1'b1; end
      else          begin data_b = f; in_w_b = 1'b1; end
      forever begin
         @(negedge clk);
         rdy = (sel == 0) ? out_r_a : out_r_b;
         if (rdy) break;
         waits++;
         if (waits > 20) begin
            check("accept_timeout", 32'(waits), 0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // flits[11*i +: 11] is flit i; returns total stall cycles seen.
   task automatic send_seq(input int sel, input logic [43:0] flits, input int n, output int stalls);
      int w;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         send_flit(sel, flits[11*i +: 11], w);
         stalls += w;
      end
   endtask

   task automatic idle(input int sel, input int ncyc);
      if (sel == 0) in_w_a = 1'b0;
      else          in_w_b = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   task automatic score(input int sel, input logic ok, input logic [1:0] src, input logic [5:0] len,
                        input logic [31:0] cnt, input logic [31:0] ecnt);
      exp_t e;
      int   avail;
      avail = (sel == 0) ? sb_q0.size() : sb_q1.size();
      check($sformatf("done_expected%0d", sel), 32'(avail != 0), 1);
      if (avail == 0) return;
      if (sel == 0) e = sb_q0.pop_front();
      else          e = sb_q1.pop_front();
      if (exp_pk[sel] < cnt_max[sel]) exp_pk[sel]++;
      if (!e.ok && exp_er[sel] < cnt_max[sel]) exp_er[sel]++;
      check($sformatf("pack_ok%0d", sel),  32'(ok),  32'(e.ok));
      check($sformatf("pack_src%0d", sel), 32'(src), 32'(e.src));
      check($sformatf("pack_len%0d", sel), 32'(len), 32'(e.len));
      check($sformatf("pack_cnt%0d", sel), cnt,  32'(exp_pk[sel]));
      check($sformatf("err_cnt%0d", sel),  ecnt, 32'(exp_er[sel]));
   endtask

   // Output monitor: closes are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (a_rst) begin
         exp_pk[0] = 0; exp_pk[1] = 0;
         exp_er[0] = 0; exp_er[1] = 0;
      end else begin
         if (done_a) score(0, ok_a, src_a, len_a, 32'(cnt_a), 32'(ecnt_a));
         if (done_b) score(1, ok_b, src_b, len_b, 32'(cnt_b), 32'(ecnt_b));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w, st;
      a_rst  = 1'b1;
      in_w_a = 1'b0; data_a = '0;
      in_w_b = 1'b0; data_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_state_a", 32'({out_r_a, done_a, ok_a, busy_a, src_a, len_a}), 0);
      check("rst_cnt_a",   32'({cnt_a, ecnt_a}), 0);
      check("rst_state_b", 32'({out_r_b, done_b, ok_b, busy_b, src_b, len_b, cnt_b, ecnt_b}), 0);
      @(posedge clk);
      #1 a_rst = 1'b0;

      // Ready still low before the first edge after reset, then 1,1,0 repeating on the stalled sink.
      @(negedge clk);
      check("rdy_first_b", 32'(out_r_b), 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("rdy_pat_b%0d", i), 32'(out_r_b), 32'((i % 3) != 2));
         check($sformatf("rdy_a%0d", i), 32'(out_r_a), 1);
      end
      @(posedge clk);
      #1;

      // Good packet
      push_exp(0, 1'b1, 2'd2, 6'd3);
      send_seq(0, {11'h502, 11'h101, 11'h100, 11'h10E}, 4, st);
      check("good_done_timing", 32'(done_a), 1);
      check("good_no_stall", 32'(st), 0);
      idle(0, 2);

      // Header-only packet followed immediately by another header
      push_exp(0, 1'b1, 2'd3, 6'd0);
      send_flit(0, 11'h503, w);
      check("hdr_only_done", 32'(done_a), 1);
      push_exp(0, 1'b1, 2'd2, 6'd1);
      send_flit(0, 11'h106, w);
      check("b2b_no_gap", 32'(w), 0);
      send_flit(0, 11'h500, w);
      idle(0, 2);

      // Early last
      push_exp(0, 1'b0, 2'd2, 6'd3);
      send_seq(0, {11'h501, 11'h100, 11'h10E}, 3, st);
      idle(0, 2);

      // Late last: resync after the second flit, a single close at the final flit
      push_exp(0, 1'b0, 2'd2, 6'd1);
      send_seq(0, {11'h100, 11'h106}, 2, st);
      check("resync_busy", 32'(busy_a), 1);
      send_seq(0, {11'h502, 11'h101}, 2, st);
      idle(0, 2);
      check("resync_idle", 32'(busy_a), 0);

      // Bad sequence, then wrong destination on the header
      push_exp(0, 1'b0, 2'd2, 6'd3);
      send_seq(0, {11'h502, 11'h101, 11'h105, 11'h10E}, 4, st);
      push_exp(0, 1'b0, 2'd2, 6'd3);
      send_seq(0, {11'h502, 11'h101, 11'h100, 11'h00E}, 4, st);
      idle(0, 2);

      // Backpressure on the stalled sink
      push_exp(1, 1'b1, 2'd2, 6'd3);
      send_seq(1, {11'h502, 11'h101, 11'h100, 11'h10E}, 4, st);
      check("stall_seen", 32'(st > 0), 1);
      idle(1, 2);

      // Saturation of the 2-bit counters
      for (int i = 0; i < 3; i++) begin
         push_exp(1, 1'b1, 2'd3, 6'd0);
         send_flit(1, 11'h503, w);
      end
      for (int i = 0; i < 4; i++) begin
         push_exp(1, 1'b0, 2'd3, 6'd0);
         send_flit(1, 11'h403, w);
      end
      idle(1, 3);
      check("sat_pack_cnt_b", 32'(cnt_b), 3);
      check("sat_err_cnt_b",  32'(ecnt_b), 3);

      // Reset in the middle of a packet
      send_seq(0, {11'h100, 11'h10E}, 2, st);
      a_rst  = 1'b1;
      in_w_a = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("midrst_rdy%0d", i), 32'(out_r_a), 0);
         check($sformatf("midrst_cnt%0d", i), 32'(cnt_a), 0);
         check($sformatf("midrst_busy%0d", i), 32'(busy_a), 0);
      end
      @(posedge clk);
      #1 a_rst = 1'b0;
      push_exp(0, 1'b1, 2'd2, 6'd3);
      send_seq(0, {11'h502, 11'h101, 11'h100, 11'h10E}, 4, st);
      idle(0, 3);
      check("after_rst_cnt", 32'(cnt_a), 1);

      check("sb_drained0", 32'(sb_q0.size()), 0);
      check("sb_drained1", 32'(sb_q1.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
